// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0)
// and data load/store (port 1), with a per-transaction timeout and sticky error flag.
module mem_port_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0,
  input  logic             i_we0,
  input  logic [WIDTH-1:0] i_addr0,
  input  logic [WIDTH-1:0] i_wdata0,
  output logic             o_ack0,
  output logic [WIDTH-1:0] o_rdata0,
  input  logic             i_req1,
  input  logic             i_we1,
  input  logic [WIDTH-1:0] i_addr1,
  input  logic [WIDTH-1:0] i_wdata1,
  output logic             o_ack1,
  output logic [WIDTH-1:0] o_rdata1,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic [WIDTH-1:0] i_mem_rdata,
  input  logic             i_mem_rdy,
  output logic             o_sel,
  output logic             o_err
);

  // Counter only needs to reach TIMEOUT-1
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_sel;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack0;
  logic             r_ack1;
  logic [WIDTH-1:0] r_rdata0;
  logic [WIDTH-1:0] r_rdata1;
  logic             r_err;

  logic             w_sel_nxt;
  logic             w_last_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ack0_nxt;
  logic             w_ack1_nxt;
  logic [WIDTH-1:0] w_rdata0_nxt;
  logic [WIDTH-1:0] w_rdata1_nxt;
  logic             w_err_nxt;
  logic             w_timeout;
  logic             w_fin;
  logic [WIDTH-1:0] w_ret;

  assign o_mem_addr  = r_sel ? i_addr1  : i_addr0;
  assign o_mem_wdata = r_sel ? i_wdata1 : i_wdata0;
  assign o_mem_we    = r_sel ? i_we1    : i_we0;
  assign o_mem_req   = (r_state == S_BUSY);

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 32'd1));
  assign w_fin     = (r_state == S_BUSY) && (i_mem_rdy || w_timeout);

  // Returned data: memory data on reads, unchanged on writes, zero on timeout
  always_comb begin
    w_ret = '0;
    if (i_mem_rdy) begin
      if (o_mem_we) w_ret = r_sel ? r_rdata1 : r_rdata0;
      else          w_ret = i_mem_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_req0 || i_req1) w_next_state = S_BUSY;
      S_BUSY:  if (w_fin) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and arbitration state
  always_comb begin
    w_sel_nxt    = r_sel;
    w_last_nxt   = r_last;
    w_cnt_nxt    = r_cnt;
    w_ack0_nxt   = 1'b0;
    w_ack1_nxt   = 1'b0;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
    w_err_nxt    = r_err;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (i_req0 && i_req1) w_sel_nxt = ~r_last;
        else if (i_req1)      w_sel_nxt = 1'b1;
        else if (i_req0)      w_sel_nxt = 1'b0;
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_fin) begin
          w_last_nxt = r_sel;
          if (!i_mem_rdy) w_err_nxt = 1'b1;
          if (r_sel) begin
            w_ack1_nxt   = 1'b1;
            w_rdata1_nxt = w_ret;
          end else begin
            w_ack0_nxt   = 1'b1;
            w_rdata0_nxt = w_ret;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sel    <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err    <= 1'b0;
    end else begin
      r_sel    <= w_sel_nxt;
      r_last   <= w_last_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ack0   <= w_ack0_nxt;
      r_ack1   <= w_ack1_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign o_sel    = r_sel;
  assign o_ack0   = r_ack0;
  assign o_ack1   = r_ack1;
  assign o_rdata0 = r_rdata0;
  assign o_rdata1 = r_rdata1;
  assign o_err    = r_err;

endmodule
